// File: rtl/uart_program_loader.sv
// UART program loader: hunts for a download frame in the received byte stream and writes the payload words to instruction flash.
// Optional inter-byte timeout enabled by defining PROGRAM_LOADER_TIMEOUT_EN.
module uart_program_loader #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h0000_0000,
  parameter int          FLASH_DEPTH    = 1024,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_data_valid,
  input  logic [7:0]  rx_data,
  output logic        flash_write_enable,
  output logic [31:0] flash_write_address,
  output logic [31:0] flash_write_data,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] word_count
);

  localparam logic [31:0] HEADER_WORD = 32'hF00F_A55A;
  localparam logic [31:0] END_WORD    = 32'h5AA5_0FF0;
  localparam logic [31:0] DEPTH_LIM   = 32'(FLASH_DEPTH);

  typedef enum logic {HUNT, PAYLOAD} state_t;

  state_t      state;
  logic [31:0] hdr_shift;
  logic [23:0] word_buf;
  logic [1:0]  byte_idx;
  logic [31:0] write_ptr;
  logic [31:0] hdr_next;
  logic [31:0] word_next;

  // Newest byte enters at the top so the oldest byte settles in [7:0].
  assign hdr_next  = {rx_data, hdr_shift[31:8]};
  assign word_next = {rx_data, word_buf};

`ifdef PROGRAM_LOADER_TIMEOUT_EN
  logic [31:0] idle_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= HUNT;
      hdr_shift           <= '0;
      byte_idx            <= '0;
      write_ptr           <= '0;
      flash_write_enable  <= 1'b0;
      flash_write_address <= '0;
      flash_write_data    <= '0;
      core_hold           <= 1'b0;
      load_done           <= 1'b0;
      load_error          <= 1'b0;
      word_count          <= '0;
`ifdef PROGRAM_LOADER_TIMEOUT_EN
      idle_cnt            <= '0;
`endif
    end else begin
      flash_write_enable <= 1'b0;
      load_done          <= 1'b0;
      case (state)
        HUNT: begin
          if (rx_data_valid) begin
            if (hdr_next == HEADER_WORD) begin
              state      <= PAYLOAD;
              hdr_shift  <= '0;
              core_hold  <= 1'b1;
              word_count <= '0;
              load_error <= 1'b0;
              write_ptr  <= BASE_ADDRESS;
              byte_idx   <= '0;
`ifdef PROGRAM_LOADER_TIMEOUT_EN
              idle_cnt   <= '0;
`endif
            end else begin
              hdr_shift <= hdr_next;
            end
          end
        end
        PAYLOAD: begin
          if (rx_data_valid) begin
`ifdef PROGRAM_LOADER_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                if (word_next == END_WORD) begin
                  load_done <= 1'b1;
                  core_hold <= 1'b0;
                  state     <= HUNT;
                end else if ({16'd0, word_count} < DEPTH_LIM) begin
                  flash_write_enable  <= 1'b1;
                  flash_write_address <= write_ptr;
                  flash_write_data    <= word_next;
                  write_ptr           <= write_ptr + 32'd4;
                  word_count          <= word_count + 16'd1;
                end else begin
                  load_error <= 1'b1;
                  core_hold  <= 1'b0;
                  state      <= HUNT;
                end
              end
            endcase
          end
`ifdef PROGRAM_LOADER_TIMEOUT_EN
          else if (idle_cnt == TIMEOUT_CYCLES - 32'd1) begin
            // Abandon the partial word; words already written stay in flash.
            load_error <= 1'b1;
            core_hold  <= 1'b0;
            state      <= HUNT;
            byte_idx   <= '0;
            idle_cnt   <= '0;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
`endif
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: a frame-level byte model predicts writes and done pulses.
// Define PROGRAM_LOADER_TIMEOUT_EN on both files to exercise the timeout path.
module tb_uart_program_loader;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 3;
  localparam logic [31:0] TMO   = 32'd100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_data_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        flash_write_enable;
  logic [31:0] flash_write_address;
  logic [31:0] flash_write_data;
  logic        core_hold;
  logic        load_done;
  logic        load_error;
  logic [15:0] word_count;

  uart_program_loader #(
    .BASE_ADDRESS(BASE), .FLASH_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data_valid(rx_data_valid), .rx_data(rx_data),
    .flash_write_enable(flash_write_enable), .flash_write_address(flash_write_address),
    .flash_write_data(flash_write_data), .core_hold(core_hold), .load_done(load_done),
    .load_error(load_error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] cnt;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;

  // Frame-level reference model state
  bit       m_pay;
  bit [7:0] m_hist[$];
  bit [7:0] m_word[$];
  int       m_cnt;
  bit [31:0] m_ptr;
  bit       m_hold, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pay = 0; m_hist.delete(); m_word.delete();
    m_cnt = 0; m_hold = 0; m_err = 0; m_ptr = BASE;
  endtask

  task automatic model_byte(input bit [7:0] b);
    ev_t e;
    bit [31:0] w;
    if (!m_pay) begin
      m_hist.push_back(b);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      if (m_hist.size() == 4 && m_hist[0] == 8'h5A && m_hist[1] == 8'hA5 &&
          m_hist[2] == 8'h0F && m_hist[3] == 8'hF0) begin
        m_pay = 1; m_hold = 1; m_err = 0; m_cnt = 0; m_ptr = BASE;
        m_hist.delete(); m_word.delete();
      end
    end else begin
      m_word.push_back(b);
      if (m_word.size() == 4) begin
        w = m_word[0] + (m_word[1] * 32'd256) + (m_word[2] * 32'd65536) + (m_word[3] * 32'd16777216);
        m_word.delete();
        if (w == 32'h5AA5_0FF0) begin
          e.is_done = 1; e.addr = 0; e.data = 0; e.cnt = 16'(m_cnt);
          sb.push_back(e);
          m_pay = 0; m_hold = 0;
        end else if (m_cnt < DEPTH) begin
          m_cnt++;
          e.is_done = 0; e.addr = m_ptr; e.data = w; e.cnt = 16'(m_cnt);
          sb.push_back(e);
          m_ptr = m_ptr + 4;
        end else begin
          m_err = 1; m_hold = 0; m_pay = 0;
        end
      end
    end
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic send_byte(input bit [7:0] b, input int gap);
    rx_data = b;
    rx_data_valid = 1'b1;
    model_byte(b);
    @(negedge clk);
    rx_data_valid = 1'b0;
    rx_data = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input bit [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], gap);
  endtask

  task automatic send_header(input int gap);
    send_word(32'hF00F_A55A, gap);
  endtask

  task automatic send_end(input int gap);
    send_word(32'h5AA5_0FF0, gap);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_status(input string pfx);
    repeat (3) @(negedge clk);
    check({pfx, "_hold"},  core_hold,  m_hold);
    check({pfx, "_error"}, load_error, m_err);
    check({pfx, "_count"}, word_count, 16'(m_cnt));
  endtask

  // Monitor: every strobe or done pulse must match the oldest predicted event
  always @(negedge clk) begin
    if (!reset && (flash_write_enable || load_done)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event we=%b done=%b addr=%h data=%h required=none",
                 flash_write_enable, load_done, flash_write_address, flash_write_data);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (e.is_done) begin
          check("done_pulse", load_done, 1);
          check("done_no_write", flash_write_enable, 0);
          check("done_count", word_count, e.cnt);
        end else begin
          check("wr_strobe", flash_write_enable, 1);
          check("wr_no_done", load_done, 0);
          check("wr_addr", flash_write_address, e.addr);
          check("wr_data", flash_write_data, e.data);
          check("wr_count", word_count, e.cnt);
        end
      end
    end
  end

  initial begin
    int n;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_we", flash_write_enable, 0);
    check("rst_addr", flash_write_address, 0);
    check("rst_data", flash_write_data, 0);
    check("rst_hold", core_hold, 0);
    check("rst_done", load_done, 0);
    check("rst_error", load_error, 0);
    check("rst_count", word_count, 0);

    // Basic two-word frame
    send_header(0);
    check("hdr_hold", core_hold, 1);
    send_word(32'h4030_2010, 0);
    send_word(32'h8070_6050, 1);
    send_end(0);
    check_status("basic");
    check("basic_count_const", word_count, 2);

    // Leading garbage, then the same frame restarts at BASE
    send_byte(8'h70, 0); send_byte(8'h80, 2);
    send_header(1);
    send_word(32'h4030_2010, 0);
    send_word(32'h8070_6050, 0);
    send_end(0);
    check_status("garbage");

    // Overflow: one more word than DEPTH
    send_header(0);
    for (int i = 0; i < DEPTH + 1; i++) send_word(32'h1111_0000 + i, 0);
    send_end(0);
    check_status("ovf");
    check("ovf_error_const", load_error, 1);
    check("ovf_count_const", word_count, DEPTH);

    // Reset mid-frame discards the partial word
    send_header(0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    do_reset();
    check("midrst_hold", core_hold, 0);
    send_header(0);
    send_word(32'h0403_0201, 0);
    send_end(0);
    check_status("midrst");

    // Non-aligned end-marker bytes and a header inside the payload are data
    send_header(0);
    send_word(32'h005A_A50F, 0);
    send_word(32'hF00F_A55A, 0);
    send_end(0);
    check_status("nearmatch");
    check("nearmatch_count_const", word_count, 2);

    // Zero-length frame
    send_header(0);
    send_end(0);
    check_status("empty");

`ifdef PROGRAM_LOADER_TIMEOUT_EN
    send_header(0);
    send_byte(8'h10, 0); send_byte(8'h20, 0);
    repeat (TMO - 2) @(negedge clk);
    check("tmo_before_hold", core_hold, 1);
    repeat (2) @(negedge clk);
    m_pay = 0; m_hold = 0; m_err = 1; m_word.delete();
    check("tmo_error", load_error, 1);
    check("tmo_hold", core_hold, 0);
    check("tmo_count", word_count, 0);
`endif

    // Randomized frames against the model
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) send_byte(8'($urandom), $urandom_range(0, 2));
      send_header($urandom_range(0, 1));
      n = $urandom_range(0, DEPTH + 1);
      for (int k = 0; k < n; k++) begin
        bit [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) == 0) w = {w[31:24], 24'h5AA50F} ^ 32'h0;
        if ($urandom_range(0, 9) == 0) w = {24'h5AA50F, w[7:0]} ;
        send_word(w, $urandom_range(0, 1));
      end
      if ($urandom_range(0, 9) == 0) begin
        send_byte(8'($urandom), 0);
        do_reset();
      end else begin
        send_end($urandom_range(0, 1));
      end
      check_status("rand");
    end

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
